int_sched: RTL
==============

# int_sched

Seven-source interrupt scheduler that sits in front of CP0. It captures INT1..INT7 events and arbitrates them by fixed priority against the CP0 interrupt mask and global enable. It tracks nested in-service levels and hands exactly one interrupt at a time to the pipeline with a READY handshake. It drives S_INT, INT_ID and the vector address INT_ENTER, which CP0 and the fetch stage consume.

## Interface
- VEC_BASE, 32'h0000_0100, vector base address
- VEC_SHIFT, 5, log2 of vector stride in bytes
- CLK  in  1  system clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- INT_IN  in  7  interrupt lines; bit 0 = INT1 … bit 6 = INT7; rising edge = event
- IM  in  7  per-source enable from CP0 Cause IM field, bit i ↔ INT_IN[i]
- IE  in  1  global interrupt enable
- PIPELINE_READY  in  1  pipeline can accept an interrupt this cycle
- ERET  in  1  one-cycle pulse: current handler returned
- INT_REQ  out  1  interrupt waiting; pipeline should drain and raise PIPELINE_READY
- S_INT  out  1  one-cycle dispatch strobe
- INT_ID  out  3  dispatched source, 1..7; 0 = none
- INT_ENTER  out  32  handler entry address
- PENDING  out  7  latched, undispatched events
- IN_SERVICE  out  7  dispatched, not yet returned

## Operation
- Edge detect: a registered copy of INT_IN (reset 0) is kept. Event = INT_IN & ~prev, so a line already high at reset release counts as one event. Each event sets its PENDING bit. Repeated events before dispatch merge.
- Priority is fixed: INT1 is highest, INT7 is lowest.
- Eligibility requires all of: PENDING bit set, IM bit set, IE = 1, and the source has strictly higher priority than the highest-priority IN_SERVICE bit. If IN_SERVICE is empty, the priority condition is satisfied.
- The winner is the highest-priority eligible source.
- FSM states: IDLE, REQ, DISPATCH.
  - IDLE: if any source is eligible, go to REQ.
  - REQ: INT_REQ = 1. The winner is re-evaluated every cycle, so a higher-priority arrival replaces the current winner.
    - If nothing is eligible any more (mask or IE cleared, or preempted by an in-service change), return to IDLE.
    - If something is eligible and PIPELINE_READY = 1, go to DISPATCH. On that same edge: latch the winner into INT_ID, clear its PENDING bit, set its IN_SERVICE bit, and load INT_ENTER.
  - DISPATCH: S_INT = 1 for exactly one cycle, then go to IDLE.
- INT_ENTER = VEC_BASE + (id << VEC_SHIFT), computed in 32 bits and wrapping modulo 2^32. It holds its value until the next dispatch.
- INT_ID holds the last dispatched id until the next dispatch.
- ERET clears the highest-priority IN_SERVICE bit. ERET with IN_SERVICE empty is a no-op.
- Simultaneous events:
  - New edge on the same source being dispatched: the clear and the set collide and the set wins, so PENDING stays 1.
  - ERET and dispatch on the same edge: the ERET clear is applied to the old IN_SERVICE first, then the new bit is set.
  - ERET while in REQ: eligibility is recomputed next cycle.
- IM and IE changes take effect in the cycle they are presented. PENDING bits are never discarded by masking.

## Timing
- Reset (asynchronous, any time, including mid-handshake): state = IDLE, INT_REQ = 0, S_INT = 0, INT_ID = 0, INT_ENTER = VEC_BASE, PENDING = 0, IN_SERVICE = 0, edge register = 0.
- Latency with PIPELINE_READY held at 1:
  - edge at cycle 0 → PENDING visible cycle 1
  - INT_REQ = 1 in cycle 2
  - S_INT = 1 in cycle 3, with INT_ID and INT_ENTER already valid
  - IDLE again in cycle 4
- PIPELINE_READY low stalls the FSM in REQ indefinitely. PIPELINE_READY is ignored outside REQ.
- Minimum spacing between two S_INT strobes is 3 cycles (DISPATCH → IDLE → REQ → DISPATCH).
- ERET takes effect on the edge it is sampled. The new IN_SERVICE value is visible the following cycle.

## Test plan
- IE = 1, IM = 7'h7F, READY = 1, single-cycle INT1 pulse → S_INT at 3rd cycle after edge, INT_ID = 1, INT_ENTER = 32'h120, IN_SERVICE = 7'h01, PENDING = 0.
- IM = 0, INT1 pulse; then IM = 7'h7F → INT_REQ stays 0 while masked and PENDING = 7'h01; after unmask, dispatch of INT_ID = 1 within 2 cycles.
- INT2 and INT3 pulsed in the same cycle → INT2 dispatched first (INT_ENTER = 32'h140). INT3 is blocked until ERET, then dispatched (INT_ENTER = 32'h160). IN_SERVICE goes 7'h02 → 0 → 7'h04.
- Nesting: INT5 in service, INT2 pulse → INT2 dispatched and IN_SERVICE = 7'h12. An INT6 pulse stays pending. ERET → 7'h10. A second ERET → 0, then INT6 dispatches.
- READY held low 10 cycles with INT4 pending, INT1 arriving mid-wait → INT_REQ held. When READY rises, INT_ID = 1 is dispatched and PENDING = 7'h08.
- RESET asserted while in REQ with PENDING = 7'h05 → all outputs immediately take their reset values, and no S_INT appears after RESET deasserts.

Source files
------------

// File: rtl/int_sched_if.sv
// Signal bundle between the interrupt scheduler and its environment (CP0, fetch, pipeline control).
// The slave modport is the scheduler's view; the master modport is the environment's view.
interface int_sched_if;
  logic [6:0]  int_in;
  logic [6:0]  im;
  logic        ie;
  logic        pipeline_ready;
  logic        eret;
  logic        int_req;
  logic        s_int;
  logic [2:0]  int_id;
  logic [31:0] int_enter;
  logic [6:0]  pending;
  logic [6:0]  in_service;

  modport slave (
    input  int_in,
    input  im,
    input  ie,
    input  pipeline_ready,
    input  eret,
    output int_req,
    output s_int,
    output int_id,
    output int_enter,
    output pending,
    output in_service
  );

  modport master (
    output int_in,
    output im,
    output ie,
    output pipeline_ready,
    output eret,
    input  int_req,
    input  s_int,
    input  int_id,
    input  int_enter,
    input  pending,
    input  in_service
  );
endinterface

// File: rtl/int_sched.sv
// Seven-source fixed-priority interrupt scheduler with nested in-service tracking.
// Source index 0 (INT1) is highest priority; one interrupt is dispatched per REQ/DISPATCH round.
module int_sched #(
  parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
  parameter int          VEC_SHIFT = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  int_sched_if.slave  bus,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_DISPATCH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  prev_q, prev_d;
  logic [6:0]  pending_q, pending_d;
  logic [6:0]  in_service_q, in_service_d;
  logic [2:0]  int_id_q, int_id_d;
  logic [31:0] int_enter_q, int_enter_d;

  logic [6:0]  evt;
  logic [6:0]  elig;
  logic [6:0]  win_oh;
  logic [6:0]  seen;
  logic [6:0]  isr_after_eret;
  logic [2:0]  win_id;
  logic        any_elig;
  logic        dispatch;

  // Event detection and eligibility. A source is blocked by any in-service
  // bit of equal or higher priority (index <= its own).
  always_comb begin
    evt  = bus.int_in & ~prev_q;
    seen = 7'd0;
    elig = 7'd0;
    for (int i = 0; i < 7; i++) begin
      seen[i] = in_service_q[i] | ((i > 0) ? seen[(i > 0) ? i - 1 : 0] : 1'b0);
      elig[i] = pending_q[i] & bus.im[i] & bus.ie & ~seen[i];
    end
    any_elig = |elig;
    win_oh   = elig & (~elig + 7'd1);
    win_id   = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (elig[i]) win_id = 3'(i + 1);
    end
  end

  // Handshake: INT_REQ is asserted throughout REQ; the pipeline accepts the
  // current winner by holding PIPELINE_READY high in a REQ cycle, and the
  // accepted interrupt is announced by the one-cycle S_INT strobe that follows.
  always_comb begin
    state_d  = state_q;
    dispatch = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_elig) state_d = S_REQ;
      end
      S_REQ: begin
        if (!any_elig) begin
          state_d = S_IDLE;
        end else if (bus.pipeline_ready) begin
          state_d  = S_DISPATCH;
          dispatch = 1'b1;
        end
      end
      S_DISPATCH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bookkeeping. A fresh edge on the dispatched source re-sets its pending
  // bit; ERET clears the highest-priority in-service bit before the new one is set.
  always_comb begin
    prev_d         = bus.int_in;
    pending_d      = (pending_q & ~(dispatch ? win_oh : 7'd0)) | evt;
    isr_after_eret = bus.eret ? (in_service_q & (in_service_q - 7'd1)) : in_service_q;
    in_service_d   = isr_after_eret | (dispatch ? win_oh : 7'd0);
    int_id_d       = dispatch ? win_id : int_id_q;
    int_enter_d    = dispatch ? (VEC_BASE + (32'(win_id) << VEC_SHIFT)) : int_enter_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      prev_q       <= 7'd0;
      pending_q    <= 7'd0;
      in_service_q <= 7'd0;
      int_id_q     <= 3'd0;
      int_enter_q  <= VEC_BASE;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      int_id_q     <= int_id_d;
      int_enter_q  <= int_enter_d;
    end
  end

  assign bus.int_req    = (state_q == S_REQ);
  assign bus.s_int      = (state_q == S_DISPATCH);
  assign bus.int_id     = int_id_q;
  assign bus.int_enter  = int_enter_q;
  assign bus.pending    = pending_q;
  assign bus.in_service = in_service_q;
  assign state_o        = state_q;

endmodule
